// File: rtl/exword_assemble_pkg.sv
// ---------------------------------------------------------------------------
// exword_assemble_pkg
//  Shared exbus definitions used by exword_assemble (and exdecompress):
//  word-type encodings, field widths, the received-byte layout, the
//  first-byte length decode and the payload slot placement helper.
// ---------------------------------------------------------------------------
package exword_assemble_pkg;

  localparam int unsigned BYTE_W = 8;   // raw receive byte
  localparam int unsigned PAY_W  = 7;   // payload bits per byte
  localparam int unsigned WORD_W = 35;  // compressed bus word
  localparam int unsigned CNT_W  = 3;   // byte count / word length
  localparam int unsigned LSB_W  = 6;   // bit index into the word

  // Word type carried in p[6:5] of the first payload byte
  typedef enum logic [1:0] {
    EXB_ADDR    = 2'b00,
    EXB_WRITE   = 2'b01,
    EXB_READ    = 2'b10,
    EXB_SPECIAL = 2'b11
  } exb_type_e;

  // Received byte: bit7 set marks a payload byte, clear marks console data
  typedef struct packed {
    logic             payload_flag;
    logic [PAY_W-1:0] data;
  } rx_byte_t;

  // Number of payload bytes in a word, decoded from its first payload byte
  function automatic logic [CNT_W-1:0] exb_wordlen(input logic [PAY_W-1:0] p);
    logic [CNT_W-1:0] len;
    len = CNT_W'(1);
    case (exb_type_e'(p[6:5]))
      EXB_ADDR, EXB_WRITE: begin
        if (!p[4])      len = CNT_W'(5);
        else if (!p[3]) len = CNT_W'(1);
        else if (!p[2]) len = CNT_W'(2);
        else            len = CNT_W'(3);
      end
      EXB_READ: len = p[4] ? CNT_W'(2) : CNT_W'(1);
      default:  len = CNT_W'(1);
    endcase
    return len;
  endfunction

  // LSB position of payload byte k inside the left-justified word
  function automatic logic [LSB_W-1:0] exb_slot_lsb(input logic [CNT_W-1:0] k);
    logic [LSB_W-1:0] lsb;
    case (k)
      CNT_W'(0): lsb = LSB_W'(28);
      CNT_W'(1): lsb = LSB_W'(21);
      CNT_W'(2): lsb = LSB_W'(14);
      CNT_W'(3): lsb = LSB_W'(7);
      default:   lsb = LSB_W'(0);
    endcase
    return lsb;
  endfunction

endpackage

// File: rtl/exword_assemble_if.sv
// ---------------------------------------------------------------------------
// exword_assemble_if
//  Byte-in / word-out / console-out handshake bundle of exword_assemble.
//   i_stb/o_busy/i_byte           incoming byte stream
//   o_stb/i_busy/o_word           assembled word stream (to exdecompress)
//   o_cons_stb/i_cons_busy/o_cons_byte  console byte stream
//   o_err                         partial word dropped on timeout (pulse)
//   o_active                      partial word in progress or word pending
//  slave  : assembler view;  master : byte source / downstream sink view.
// ---------------------------------------------------------------------------
interface exword_assemble_if;
  import exword_assemble_pkg::*;

  logic              i_stb;
  logic              o_busy;
  logic [BYTE_W-1:0] i_byte;
  logic              o_stb;
  logic              i_busy;
  logic [WORD_W-1:0] o_word;
  logic              o_cons_stb;
  logic              i_cons_busy;
  logic [PAY_W-1:0]  o_cons_byte;
  logic              o_err;
  logic              o_active;

  modport slave (
    input  i_stb, i_byte, i_busy, i_cons_busy,
    output o_busy, o_stb, o_word, o_cons_stb, o_cons_byte, o_err, o_active
  );

  modport master (
    output i_stb, i_byte, i_busy, i_cons_busy,
    input  o_busy, o_stb, o_word, o_cons_stb, o_cons_byte, o_err, o_active
  );

endinterface

// File: rtl/exword_assemble.sv
// ---------------------------------------------------------------------------
// exword_assemble
//  Splits the raw receive byte stream into compressed 35-bit bus words
//  (bytes with bit7=1, 7 payload bits each, packed left-justified) and a
//  console byte stream (bytes with bit7=0). Partial words left idle for
//  2^TIMEOUT_BITS-1 clocks are dropped with a one-clock o_err pulse.
//  Ports:
//   i_clk    system clock
//   i_reset  synchronous active-high reset
//   bus      exword_assemble_if.slave (byte in, word out, console out)
//  Parameters:
//   OPT_LOWPOWER  zero o_word / o_cons_byte while their strobe is low
//   TIMEOUT_BITS  idle counter width; 0 disables the timeout
// ---------------------------------------------------------------------------
module exword_assemble
  import exword_assemble_pkg::*;
#(
  parameter bit          OPT_LOWPOWER = 1'b0,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input logic              i_clk,
  input logic              i_reset,
  exword_assemble_if.slave bus
);

  localparam int unsigned IDLE_W     = (TIMEOUT_BITS == 0) ? 1 : TIMEOUT_BITS;
  localparam bit          TIMEOUT_EN = (TIMEOUT_BITS != 0);

  rx_byte_t          rx;
  logic              busy;
  logic              acc;
  logic              acc_pay;
  logic              acc_cons;

  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              stb_q, stb_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              cons_stb_q, cons_stb_d;
  logic [PAY_W-1:0]  cons_byte_q, cons_byte_d;
  logic              err_q, err_d;

  logic [CNT_W-1:0]  len_now;
  logic [WORD_W-1:0] slot;
  logic [WORD_W-1:0] merged;
  logic              word_done;
  logic              timeout;

  // Input acceptance: one byte per clock, held off while either output stalls
  assign rx       = rx_byte_t'(bus.i_byte);
  assign busy     = (stb_q && bus.i_busy) || (cons_stb_q && bus.i_cons_busy);
  assign acc      = bus.i_stb && !busy;
  assign acc_pay  = acc && rx.payload_flag;
  assign acc_cons = acc && !rx.payload_flag;

  // Word assembly: byte count, latched length, shift register, idle timer
  always_comb begin
    count_d = count_q;
    len_d   = len_q;
    sreg_d  = sreg_q;
    idle_d  = idle_q;
    err_d   = 1'b0;

    // Length comes from byte 0 itself when a word is starting
    len_now   = (count_q == '0) ? exb_wordlen(rx.data) : len_q;
    slot      = WORD_W'(rx.data) << exb_slot_lsb(count_q);
    merged    = (count_q == '0) ? slot : (sreg_q | slot);
    word_done = acc_pay && (CNT_W'(count_q + 1'b1) == len_now);
    // An accepted payload byte on the all-ones clock beats the timeout
    timeout   = TIMEOUT_EN && (count_q != '0) && !acc_pay && (idle_q == '1);

    if (acc_pay) begin
      sreg_d  = merged;
      len_d   = len_now;
      count_d = word_done ? '0 : CNT_W'(count_q + 1'b1);
      idle_d  = '0;
    end else if (timeout) begin
      sreg_d  = '0;
      count_d = '0;
      idle_d  = '0;
      err_d   = 1'b1;
    end else if (count_q == '0 || !TIMEOUT_EN) begin
      idle_d  = '0;
    end else begin
      idle_d  = IDLE_W'(idle_q + 1'b1);
    end
  end

  // Output streams: data held stable while the strobe is stalled
  always_comb begin
    stb_d       = (stb_q && bus.i_busy) || word_done;
    word_d      = word_done ? merged : word_q;
    cons_stb_d  = (cons_stb_q && bus.i_cons_busy) || acc_cons;
    cons_byte_d = acc_cons ? rx.data : cons_byte_q;

    if (OPT_LOWPOWER && !stb_d)      word_d      = '0;
    if (OPT_LOWPOWER && !cons_stb_d) cons_byte_d = '0;
  end

  // State registers; output data is only cleared by reset in low-power mode
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q    <= '0;
      len_q      <= '0;
      sreg_q     <= '0;
      idle_q     <= '0;
      stb_q      <= 1'b0;
      cons_stb_q <= 1'b0;
      err_q      <= 1'b0;
      if (OPT_LOWPOWER) begin
        word_q      <= '0;
        cons_byte_q <= '0;
      end
    end else begin
      count_q     <= count_d;
      len_q       <= len_d;
      sreg_q      <= sreg_d;
      idle_q      <= idle_d;
      stb_q       <= stb_d;
      word_q      <= word_d;
      cons_stb_q  <= cons_stb_d;
      cons_byte_q <= cons_byte_d;
      err_q       <= err_d;
    end
  end

  assign bus.o_busy      = busy;
  assign bus.o_stb       = stb_q;
  assign bus.o_word      = word_q;
  assign bus.o_cons_stb  = cons_stb_q;
  assign bus.o_cons_byte = cons_byte_q;
  assign bus.o_err       = err_q;
  assign bus.o_active    = (count_q != '0) || stb_q;

endmodule
